// File: rtl/eBike_pkg.sv
// Shared constants and types for the eBike telemetry link.
// Parser and byte-receiver state encodings are exported for debug observation.
package eBike_pkg;

    localparam logic [7:0] TELEM_HDR0    = 8'hAA;
    localparam logic [7:0] TELEM_HDR1    = 8'h55;
    localparam int         TELEM_PKT_LEN = 8;

    typedef enum logic [2:0] {
        WAIT_AA,
        WAIT_55,
        B_H,
        B_L,
        C_H,
        C_L,
        T_H,
        T_L
    } parse_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_RECV,
        RX_WAIT_HI
    } rx_state_t;

    typedef struct packed {
        rx_state_t    rx;
        parse_state_t parse;
    } telem_dbg_t;

endpackage

// File: rtl/UART_rx.sv
// UART byte receiver: 2-flop synchronizer, falling-edge start detect, mid-bit sampling.
// rdy/frm_err are single-cycle pulses on the stop-bit sample; rx_data is valid with rdy.
module UART_rx
    import eBike_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rdy,
    output logic       frm_err,
    output rx_state_t  dbg_state
);

    localparam int CW = $clog2(BAUD_DIV + 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV);

    logic            r_rx_meta;
    logic            r_rx_sync;
    logic            r_rx_prev;
    rx_state_t       r_state;
    rx_state_t       w_next;
    logic [CW-1:0]   r_baud_cnt;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_shift;
    logic            w_start;
    logic            w_tick;
    logic            w_rdy;
    logic            w_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    assign w_start = (r_state == RX_IDLE) && r_rx_prev && !r_rx_sync;
    assign w_tick  = (r_state == RX_RECV) && (r_baud_cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RX_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_rdy  = 1'b0;
        w_ferr = 1'b0;
        case (r_state)
            RX_IDLE: if (w_start) w_next = RX_RECV;
            RX_RECV: begin
                if (w_tick) begin
                    // A high start sample means the falling edge was a glitch.
                    if (r_bit_cnt == 4'd0 && r_rx_sync) begin
                        w_next = RX_IDLE;
                    end else if (r_bit_cnt == 4'd9) begin
                        if (r_rx_sync) begin
                            w_rdy  = 1'b1;
                            w_next = RX_IDLE;
                        end else begin
                            w_ferr = 1'b1;
                            w_next = RX_WAIT_HI;
                        end
                    end
                end
            end
            RX_WAIT_HI: if (r_rx_sync) w_next = RX_IDLE;
            default: w_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= 4'd0;
            r_shift    <= 8'h00;
        end else if (w_start) begin
            r_baud_cnt <= HALF_LOAD;
            r_bit_cnt  <= 4'd0;
        end else if (r_state == RX_RECV) begin
            if (w_tick) begin
                r_baud_cnt <= FULL_LOAD;
                r_bit_cnt  <= r_bit_cnt + 4'd1;
                if (r_bit_cnt >= 4'd1 && r_bit_cnt <= 4'd8)
                    r_shift <= {r_rx_sync, r_shift[7:1]};
            end else begin
                r_baud_cnt <= r_baud_cnt - CW'(1);
            end
        end
    end

    assign rx_data   = r_shift;
    assign rdy       = w_rdy;
    assign frm_err   = w_ferr;
    assign dbg_state = r_state;

endmodule

// File: rtl/telemetry_rx.sv
// Telemetry packet receiver: parses AA 55 BH BL CH CL TH TL and publishes the
// three 12-bit values together with a one-cycle pkt_vld; framing/format/timeout -> pkt_err.
module telemetry_rx
    import eBike_pkg::*;
#(
    parameter int BAUD_DIV     = 2604,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic [11:0] batt_v,
    output logic [11:0] avg_curr,
    output logic [11:0] avg_torque,
    output logic        pkt_vld,
    output logic        pkt_err,
    output telem_dbg_t  dbg_state
);

    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    logic [7:0]    w_byte;
    logic          w_rdy;
    logic          w_frm_err;
    rx_state_t     w_rx_state;
    parse_state_t  r_state;
    parse_state_t  w_next;
    logic          w_vld;
    logic          w_err;
    logic          w_timeout;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_bh;
    logic [7:0]    r_bl;
    logic [3:0]    r_ch;
    logic [7:0]    r_cl;
    logic [3:0]    r_th;
    logic [11:0]   r_batt_v;
    logic [11:0]   r_avg_curr;
    logic [11:0]   r_avg_torque;
    logic          r_pkt_vld;
    logic          r_pkt_err;

    UART_rx #(.BAUD_DIV(BAUD_DIV)) u_uart_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .rx_data   (w_byte),
        .rdy       (w_rdy),
        .frm_err   (w_frm_err),
        .dbg_state (w_rx_state)
    );

    // A byte arriving on the expiry cycle wins over the timeout.
    assign w_timeout = (r_state != WAIT_AA) && !w_rdy && (r_to_cnt >= TW'(TO_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      r_to_cnt <= '0;
        else if (w_rdy)                  r_to_cnt <= '0;
        else if (r_to_cnt != TW'(TO_LIMIT)) r_to_cnt <= r_to_cnt + TW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT_AA;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_vld  = 1'b0;
        w_err  = 1'b0;
        if (w_frm_err || w_timeout) begin
            w_next = WAIT_AA;
            w_err  = 1'b1;
        end else if (w_rdy) begin
            case (r_state)
                WAIT_AA: if (w_byte == TELEM_HDR0) w_next = WAIT_55;
                WAIT_55: begin
                    if (w_byte == TELEM_HDR1) begin
                        w_next = B_H;
                    end else if (w_byte != TELEM_HDR0) begin
                        w_next = WAIT_AA;
                        w_err  = 1'b1;
                    end
                end
                B_H, C_H, T_H: begin
                    if (w_byte[7:4] != 4'h0) begin
                        w_next = WAIT_AA;
                        w_err  = 1'b1;
                    end else begin
                        w_next = (r_state == B_H) ? B_L : (r_state == C_H) ? C_L : T_L;
                    end
                end
                B_L: w_next = C_H;
                C_L: w_next = T_H;
                T_L: begin
                    w_next = WAIT_AA;
                    w_vld  = 1'b1;
                end
                default: w_next = WAIT_AA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bh         <= 4'h0;
            r_bl         <= 8'h00;
            r_ch         <= 4'h0;
            r_cl         <= 8'h00;
            r_th         <= 4'h0;
            r_batt_v     <= 12'h000;
            r_avg_curr   <= 12'h000;
            r_avg_torque <= 12'h000;
            r_pkt_vld    <= 1'b0;
            r_pkt_err    <= 1'b0;
        end else begin
            r_pkt_vld <= w_vld;
            r_pkt_err <= w_err;
            if (w_rdy && !w_err) begin
                case (r_state)
                    B_H:     r_bh <= w_byte[3:0];
                    B_L:     r_bl <= w_byte;
                    C_H:     r_ch <= w_byte[3:0];
                    C_L:     r_cl <= w_byte;
                    T_H:     r_th <= w_byte[3:0];
                    default: ;
                endcase
            end
            if (w_vld) begin
                r_batt_v     <= {r_bh, r_bl};
                r_avg_curr   <= {r_ch, r_cl};
                r_avg_torque <= {r_th, w_byte};
            end
        end
    end

    assign batt_v     = r_batt_v;
    assign avg_curr   = r_avg_curr;
    assign avg_torque = r_avg_torque;
    assign pkt_vld    = r_pkt_vld;
    assign pkt_err    = r_pkt_err;
    assign dbg_state  = {w_rx_state, r_state};

endmodule

// File: tb/tb_telemetry_rx.sv
// Directed bench for telemetry_rx: good packets, resync, format/framing/timeout
// errors, asynchronous reset mid-packet and back-to-back streaming.
module tb_telemetry_rx;
    import eBike_pkg::*;

    localparam int BD = 16;
    localparam int TB = 20;

    logic        clk;
    logic        rst_n;
    logic        RX;
    logic [11:0] batt_v;
    logic [11:0] avg_curr;
    logic [11:0] avg_torque;
    logic        pkt_vld;
    logic        pkt_err;
    telem_dbg_t  dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vld_cnt = 0;
    int err_cnt = 0;
    int vld_cyc = 0;
    int err_cyc = 0;
    int stop_cyc = 0;

    telemetry_rx #(.BAUD_DIV(BD), .TIMEOUT_BITS(TB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX         (RX),
        .batt_v     (batt_v),
        .avg_curr   (avg_curr),
        .avg_torque (avg_torque),
        .pkt_vld    (pkt_vld),
        .pkt_err    (pkt_err),
        .dbg_state  (dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (pkt_vld) begin
                vld_cnt++;
                vld_cyc = cyc;
            end
            if (pkt_err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (pkt_vld || pkt_err) check("vld_err_exclusive", {31'b0, pkt_vld & pkt_err}, 32'd0);
        end
    end

    // driver tasks
    task automatic drive_bit(input logic b);
        @(negedge clk);
        RX = b;
        repeat (BD - 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        stop_cyc = cyc;
        drive_bit(stop);
    endtask

    task automatic idle_bits(input int n);
        @(negedge clk);
        RX = 1'b1;
        repeat (n * BD - 1) @(negedge clk);
    endtask

    task automatic send_pkt(input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte({4'h0, b[11:8]}, 1'b1);
        send_byte(b[7:0], 1'b1);
        send_byte({4'h0, c[11:8]}, 1'b1);
        send_byte(c[7:0], 1'b1);
        send_byte({4'h0, t[11:8]}, 1'b1);
        send_byte(t[7:0], 1'b1);
    endtask

    task automatic check_out(input string tag, input logic [11:0] b, input logic [11:0] c, input logic [11:0] t);
        check({tag, "_batt_v"}, {20'b0, batt_v}, {20'b0, b});
        check({tag, "_avg_curr"}, {20'b0, avg_curr}, {20'b0, c});
        check({tag, "_avg_torque"}, {20'b0, avg_torque}, {20'b0, t});
    endtask

    initial begin
        int v0;
        int e0;
        int d;
        logic [7:0] bytes_resync [10];
        rst_n = 1'b0;
        RX    = 1'b1;
        repeat (4) @(negedge clk);
        check_out("reset", 12'h000, 12'h000, 12'h000);
        check("reset_pkt_vld", {31'b0, pkt_vld}, 32'd0);
        check("reset_pkt_err", {31'b0, pkt_err}, 32'd0);
        rst_n = 1'b1;
        idle_bits(2);

        // good packet with latency check
        v0 = vld_cnt; e0 = err_cnt;
        send_pkt(12'hA98, 12'h123, 12'h456);
        idle_bits(2);
        check("good_vld_count", vld_cnt - v0, 32'd1);
        check("good_err_count", err_cnt - e0, 32'd0);
        d = vld_cyc - stop_cyc;
        check("good_latency_window", {31'b0, (d >= 8 && d <= 16)}, 32'd1);
        check_out("good", 12'hA98, 12'h123, 12'h456);

        // resync through junk and a repeated header byte
        bytes_resync = '{8'h37, 8'hAA, 8'hAA, 8'h55, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h0C, 8'h00};
        v0 = vld_cnt; e0 = err_cnt;
        for (int i = 0; i < 10; i++) send_byte(bytes_resync[i], 1'b1);
        idle_bits(2);
        check("resync_vld_count", vld_cnt - v0, 32'd1);
        check("resync_err_count", err_cnt - e0, 32'd0);
        check_out("resync", 12'hFFF, 12'h000, 12'hC00);

        // format error on high-nibble byte
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h1A, 1'b1);
        send_byte(8'h98, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h56, 1'b1);
        idle_bits(2);
        check("fmt_err_count", err_cnt - e0, 32'd1);
        check("fmt_vld_count", vld_cnt - v0, 32'd0);
        check_out("fmt_hold", 12'hFFF, 12'h000, 12'hC00);
        v0 = vld_cnt;
        send_pkt(12'h321, 12'hBCD, 12'h7EF);
        idle_bits(2);
        check("fmt_after_vld", vld_cnt - v0, 32'd1);
        check_out("fmt_after", 12'h321, 12'hBCD, 12'h7EF);

        // framing error on byte 5
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'h98, 1'b1);
        send_byte(8'h01, 1'b0);
        idle_bits(2);
        send_byte(8'h23, 1'b1);
        send_byte(8'h04, 1'b1);
        send_byte(8'h56, 1'b1);
        idle_bits(2);
        check("frm_err_count", err_cnt - e0, 32'd1);
        check("frm_vld_count", vld_cnt - v0, 32'd0);
        check_out("frm_hold", 12'h321, 12'hBCD, 12'h7EF);
        v0 = vld_cnt;
        send_pkt(12'hA98, 12'h123, 12'h456);
        idle_bits(2);
        check("frm_after_vld", vld_cnt - v0, 32'd1);
        check_out("frm_after", 12'hA98, 12'h123, 12'h456);

        // inter-byte timeout
        v0 = vld_cnt; e0 = err_cnt;
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        idle_bits(25);
        check("to_err_count", err_cnt - e0, 32'd1);
        check("to_vld_count", vld_cnt - v0, 32'd0);
        d = err_cyc - stop_cyc;
        check("to_time_window", {31'b0, (d >= TB * BD + 5 && d <= TB * BD + 20)}, 32'd1);
        check("to_parser_idle", {29'b0, dbg.parse}, {29'b0, WAIT_AA});
        v0 = vld_cnt;
        send_pkt(12'h321, 12'hBCD, 12'h7EF);
        idle_bits(2);
        check("to_after_vld", vld_cnt - v0, 32'd1);
        check_out("to_after", 12'h321, 12'hBCD, 12'h7EF);

        // asynchronous reset in the middle of byte 4
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_byte(8'h0A, 1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_out("midrst", 12'h000, 12'h000, 12'h000);
        check("midrst_pkt_vld", {31'b0, pkt_vld}, 32'd0);
        check("midrst_pkt_err", {31'b0, pkt_err}, 32'd0);
        RX = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(2);
        v0 = vld_cnt; e0 = err_cnt;
        send_pkt(12'hA98, 12'h123, 12'h456);
        idle_bits(2);
        check("postrst_vld", vld_cnt - v0, 32'd1);
        check("postrst_err", err_cnt - e0, 32'd0);
        check_out("postrst", 12'hA98, 12'h123, 12'h456);

        // ten back-to-back packets, no idle between frames
        v0 = vld_cnt; e0 = err_cnt;
        for (int p = 0; p < 10; p++)
            send_pkt(12'(p * 12'h111), 12'(12'h800 + p * 3), 12'hABC ^ 12'(p));
        idle_bits(2);
        check("stream_vld_count", vld_cnt - v0, 32'd10);
        check("stream_err_count", err_cnt - e0, 32'd0);
        check_out("stream_last", 12'h999, 12'h81B, 12'hAB5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/telemetry_rx.md
Name: telemetry_rx

Overview:
Receive side of the eBike telemetry link. It deserializes the 8-byte UART telemetry packet carrying battery voltage, average current and average torque, and checks the framing. It presents the three 12-bit values atomically with a one-cycle valid strobe. It is used in the bench/host-side model and the display board, and is the counterpart of the telemetry transmitter.

Parameters:
BAUD_DIV, 2604, clocks per UART bit (50 MHz / 19200 baud); the bench uses 16.
TIMEOUT_BITS, 20, maximum idle gap between bytes inside a packet, in bit times.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  serial line, idle high, asynchronous to clk
batt_v  output  12  battery voltage from the last good packet
avg_curr  output  12  average current from the last good packet
avg_torque  output  12  average torque from the last good packet
pkt_vld  output  1  one-cycle pulse when the three outputs update
pkt_err  output  1  one-cycle pulse on any framing or format error

Behaviour:
- Reset: batt_v, avg_curr and avg_torque are 0; pkt_vld and pkt_err are 0. The RX synchronizer flops preset to 1. Byte receiver is idle; parser is in WAIT_AA.
- RX synchronization: two flops, then an edge detect. Start condition is a falling edge of the synchronized RX while the receiver is idle.
- Byte receiver sampling:
  - Baud counter loads BAUD_DIV/2 at the start edge, so sampling lands mid-bit. It reloads BAUD_DIV after each sample.
  - 10 samples are taken: start bit, 8 data bits LSB-first, stop bit.
  - If the start sample is 1: glitch. The receiver returns to idle with no error.
- Byte receiver completion:
  - Stop bit = 1: assert an internal byte_rdy for one cycle with the byte.
  - Stop bit = 0: assert an internal frame_err for one cycle. The receiver waits for RX high before re-arming.
- Packet format, bytes in order: 0xAA, 0x55, {4'h0,batt_v[11:8]}, batt_v[7:0], {4'h0,avg_curr[11:8]}, avg_curr[7:0], {4'h0,avg_torque[11:8]}, avg_torque[7:0].
- Parser FSM states: WAIT_AA, WAIT_55, B_H, B_L, C_H, C_L, T_H, T_L. It advances one state per byte_rdy.
- Parser header handling:
  - WAIT_AA: 0xAA goes to WAIT_55; any other byte stays, with no error.
  - WAIT_55: 0x55 goes to B_H; 0xAA stays in WAIT_55; any other byte goes to WAIT_AA and pulses pkt_err.
- Parser high-nibble bytes (B_H, C_H, T_H): if byte[7:4] != 0, pulse pkt_err and go to WAIT_AA.
- Parser data capture:
  - Bytes go into shadow registers only.
  - On byte_rdy in T_L, the shadows and that byte are copied to the outputs on the same edge that asserts pkt_vld. Latency is 1 clk after byte_rdy; the parser then returns to WAIT_AA.
  - Outputs never change except together with pkt_vld.
- Error cases:
  - frame_err in any state pulses pkt_err and returns the parser to WAIT_AA; the shadows are discarded.
  - Inter-byte timeout: in states other than WAIT_AA, if no byte_rdy arrives within TIMEOUT_BITS*BAUD_DIV clocks after the previous byte_rdy, pulse pkt_err once and go to WAIT_AA.
  - The timeout counter is cleared on every byte_rdy and saturates rather than wrapping.
- Simultaneous events: frame_err and timeout expiring on the same cycle produce a single pkt_err pulse. pkt_vld and pkt_err are never both high.
- Reset mid-byte or mid-packet aborts all activity immediately. The first packet after reset must start with a fresh 0xAA.
- Back-to-back packets with zero idle between stop and start bits must be received without loss.

Decomposition:
- Package eBike_pkg: constants TELEM_HDR0 = 8'hAA and TELEM_HDR1 = 8'h55, the parser state enum, and the packet length of 8.
- Sub-module UART_rx (clk, rst_n, RX, rx_data[7:0], rdy, frm_err) holds the synchronizer, baud counter and shift register, parameterized by BAUD_DIV.
- telemetry_rx instantiates UART_rx and contains the parser FSM, shadow registers and timeout counter.

Test Plan:
- Good packet: send AA 55 0A 98 01 23 04 56 with BAUD_DIV=16 -> exactly one pkt_vld, one clk after the last stop bit sample; batt_v=12'hA98, avg_curr=12'h123, avg_torque=12'h456; pkt_err never asserted.
- Resync: send 37 AA AA 55 0F FF 00 00 0C 00 -> no pkt_err; outputs become FFF/000/C00 with one pkt_vld.
- Format error: send AA 55 1A ... -> pkt_err pulse on the third byte; outputs keep their previous values. A following good packet is accepted.
- Framing error: force the stop bit low on byte 5 -> one pkt_err, no pkt_vld. A following good packet is accepted.
- Timeout: send AA 55 0A, then idle 25 bit times -> single pkt_err at 20 bit times; the parser returns to WAIT_AA and a subsequent packet is accepted.
- Reset and streaming:
  - Assert rst_n low midway through byte 4 -> all outputs are 0 immediately.
  - After release, a new good packet is received correctly.
  - 10 back-to-back packets yield 10 pkt_vld pulses.
